// File: rtl/prism_in_filter_pkg.sv
// prism_in_filter_pkg: register map, field positions and sticky-status helper for the input filter
package prism_in_filter_pkg;
  localparam logic [1:0] A_CTRL     = 2'd0;
  localparam logic [1:0] A_EDGE_EN  = 2'd1;
  localparam logic [1:0] A_STATUS   = 2'd2;
  localparam logic [1:0] A_IRQ_MASK = 2'd3;
  localparam int FILT_LEN_LSB = 0;
  localparam int FILT_EN_LSB  = 8;
  localparam int RISE_LSB     = 0;
  localparam int FALL_LSB     = 8;
  localparam int FILT_OUT_LSB = 16;
  function automatic logic [7:0] sticky_next(input logic [7:0] st, input logic [7:0] set, input logic [7:0] clr);
    return (st & ~clr) | set;
  endfunction
endpackage

// File: rtl/prism_in_filter_bit.sv
// prism_in_filter_bit: per-pin glitch filter with saturating run counter and edge pulses
module prism_in_filter_bit #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pin,
  input  logic             i_bypass,
  input  logic [CNT_W-1:0] i_filt_len,
  output logic             o_filt,
  output logic             o_rise,
  output logic             o_fall
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_toggle;
  assign w_diff   = i_pin != r_filt;
  // a lowered length compares against the already-accumulated count, so >= rather than ==
  assign w_toggle = w_diff & (i_bypass | (r_cnt >= i_filt_len - 1'b1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= (i_bypass | ~w_diff | w_toggle) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      r_filt <= r_filt ^ w_toggle;
      r_rise <= w_toggle & ~r_filt;
      r_fall <= w_toggle & r_filt;
    end
  end
  assign o_filt = r_filt;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/prism_in_filter.sv
// prism_in_filter: register block, sticky edge status and edge interrupt around per-pin filters
module prism_in_filter
  import prism_in_filter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_pin_in,
  input  logic             i_cfg_wr,
  input  logic [1:0]       i_cfg_addr,
  input  logic [31:0]      i_cfg_wdata,
  output logic [31:0]      o_cfg_rdata,
  output logic [WIDTH-1:0] o_filt_out,
  output logic [WIDTH-1:0] o_rise_pulse,
  output logic [WIDTH-1:0] o_fall_pulse,
  output logic             o_edge_irq
);
  logic [CNT_W-1:0] r_filt_len;
  logic [7:0]       r_filt_en;
  logic [7:0]       r_rise_en;
  logic [7:0]       r_fall_en;
  logic [7:0]       r_rise_st;
  logic [7:0]       r_fall_st;
  logic [7:0]       r_mask_r;
  logic [7:0]       r_mask_f;
  logic             r_irq;
  logic [7:0]       w_rise8;
  logic [7:0]       w_fall8;
  logic [15:0]      w_clr;
  logic [WIDTH-1:0] w_bypass;
  logic             w_unused;
  assign w_rise8  = 8'(o_rise_pulse);
  assign w_fall8  = 8'(o_fall_pulse);
  assign w_clr    = (i_cfg_wr && i_cfg_addr == A_STATUS) ? i_cfg_wdata[15:0] : 16'h0;
  assign w_unused = ^{i_cfg_wdata[31:16], r_filt_en};
  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_pin
      assign w_bypass[g] = ~r_filt_en[g] | (r_filt_len == '0);
      prism_in_filter_bit #(.CNT_W(CNT_W)) u_bit (
        .clk        (clk),
        .rst        (rst),
        .i_pin      (i_pin_in[g]),
        .i_bypass   (w_bypass[g]),
        .i_filt_len (r_filt_len),
        .o_filt     (o_filt_out[g]),
        .o_rise     (o_rise_pulse[g]),
        .o_fall     (o_fall_pulse[g])
      );
    end
  endgenerate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_len <= '0;
      r_filt_en  <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_rise_st  <= '0;
      r_fall_st  <= '0;
      r_mask_r   <= '0;
      r_mask_f   <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (i_cfg_wr && i_cfg_addr == A_CTRL) begin
        r_filt_len <= i_cfg_wdata[FILT_LEN_LSB +: CNT_W];
        r_filt_en  <= i_cfg_wdata[FILT_EN_LSB +: 8];
      end
      if (i_cfg_wr && i_cfg_addr == A_EDGE_EN) begin
        r_rise_en <= i_cfg_wdata[RISE_LSB +: 8];
        r_fall_en <= i_cfg_wdata[FALL_LSB +: 8];
      end
      if (i_cfg_wr && i_cfg_addr == A_IRQ_MASK) begin
        r_mask_r <= i_cfg_wdata[RISE_LSB +: 8];
        r_mask_f <= i_cfg_wdata[FALL_LSB +: 8];
      end
      // set is ORed in after the clear so a coincident new edge is never lost
      r_rise_st <= sticky_next(r_rise_st, w_rise8 & r_rise_en, w_clr[RISE_LSB +: 8]);
      r_fall_st <= sticky_next(r_fall_st, w_fall8 & r_fall_en, w_clr[FALL_LSB +: 8]);
      r_irq     <= |((r_rise_st & r_mask_r) | (r_fall_st & r_mask_f));
    end
  end
  always_comb begin
    o_cfg_rdata = (i_cfg_addr == A_CTRL)    ? {16'h0, r_filt_en, 8'(r_filt_len)} :
                  (i_cfg_addr == A_EDGE_EN) ? {16'h0, r_fall_en, r_rise_en} :
                  (i_cfg_addr == A_STATUS)  ? {8'h0, 8'(o_filt_out), r_fall_st, r_rise_st} :
                                              {16'h0, r_mask_f, r_mask_r};
  end
  assign o_edge_irq = r_irq;
endmodule

// File: tb/tb_prism_in_filter.sv
// tb_prism_in_filter: directed stimulus checked every cycle against a sample-history model
module tb_prism_in_filter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pin = 8'h00;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  filt, rise, fall;
  logic        irq;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prism_in_filter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_pin_in(pin), .i_cfg_wr(wr), .i_cfg_addr(addr),
    .i_cfg_wdata(wdata), .o_cfg_rdata(rdata), .o_filt_out(filt),
    .o_rise_pulse(rise), .o_fall_pulse(fall), .o_edge_irq(irq)
  );

  // model: a filtered pin flips once its most recent FILT_LEN samples all disagree with it
  logic [7:0] m_filt, m_rise, m_fall, m_en, m_ren, m_fen, m_rst, m_fst, m_mr, m_mf, m_nf, m_cr, m_cf;
  logic [3:0] m_len;
  logic       m_irq;
  logic [7:0] hist[$];
  int         run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_filt, m_rise, m_fall, m_en, m_ren, m_fen, m_rst, m_fst, m_mr, m_mf} = '0;
      m_len = 0; m_irq = 0;
      hist.delete();
    end else begin
      hist.push_front(pin);
      if (hist.size() > 40) void'(hist.pop_back());
      for (int i = 0; i < 8; i++) begin
        if (!m_en[i] || m_len == 0) m_nf[i] = pin[i];
        else begin
          run = 0;
          while (run < hist.size() && hist[run][i] != m_filt[i]) run++;
          m_nf[i] = (run >= int'(m_len)) ? ~m_filt[i] : m_filt[i];
        end
      end
      m_cr = (wr && addr == 2'd2) ? wdata[7:0] : 8'h0;
      m_cf = (wr && addr == 2'd2) ? wdata[15:8] : 8'h0;
      m_irq = |((m_rst & m_mr) | (m_fst & m_mf));
      m_rst = (m_rst & ~m_cr) | (m_rise & m_ren);
      m_fst = (m_fst & ~m_cf) | (m_fall & m_fen);
      m_rise = m_nf & ~m_filt;
      m_fall = ~m_nf & m_filt;
      m_filt = m_nf;
      if (wr) begin
        if (addr == 2'd0) begin m_len = wdata[3:0]; m_en = wdata[15:8]; end
        if (addr == 2'd1) begin m_ren = wdata[7:0]; m_fen = wdata[15:8]; end
        if (addr == 2'd3) begin m_mr = wdata[7:0]; m_mf = wdata[15:8]; end
      end
    end
  end

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_en, 4'h0, m_len};
      2'd1:    return {16'h0, m_fen, m_ren};
      2'd2:    return {8'h0, m_filt, m_fst, m_rst};
      default: return {16'h0, m_mf, m_mr};
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("filt_out", 32'(filt), 32'(m_filt));
    cmp("rise_pulse", 32'(rise), 32'(m_rise));
    cmp("fall_pulse", 32'(fall), 32'(m_fall));
    cmp("edge_irq", 32'(irq), 32'(m_irq));
    cmp("cfg_rdata", rdata, m_rdata(addr));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick(1);
    wr = 1'b0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    cmp("reset_filt", 32'(filt), 32'h0);
    cmp("reset_irq", 32'(irq), 32'h0);
    // bypass: one-cycle latency and single-cycle pulses
    pin[3] = 1'b1; tick(1);
    cmp("byp_filt", 32'(filt), 32'h08);
    cmp("byp_rise", 32'(rise), 32'h08);
    tick(1);
    cmp("byp_rise_gone", 32'(rise), 32'h00);
    pin[3] = 1'b0; tick(1);
    cmp("byp_fall", 32'(fall), 32'h08);
    // glitch filter, length 4 on pin 0
    wreg(2'd0, 32'h0000_0104);
    pin[0] = 1'b1; tick(3);
    pin[0] = 1'b0; tick(1);
    cmp("glitch_reject", 32'(filt), 32'h00);
    tick(2);
    pin[0] = 1'b1; tick(3);
    cmp("glitch_wait", 32'(filt), 32'h00);
    tick(1);
    cmp("glitch_pass", 32'(filt), 32'h01);
    cmp("glitch_rise", 32'(rise), 32'h01);
    pin[0] = 1'b0; tick(5);
    // sticky status and interrupt on pin 2
    wreg(2'd1, 32'h0000_0004);
    wreg(2'd3, 32'h0000_0004);
    addr = 2'd2;
    pin[2] = 1'b1; tick(1);
    cmp("sticky_pulse", 32'(rise), 32'h04);
    tick(1);
    cmp("sticky_status", rdata & 32'hFFFF, 32'h0004);
    cmp("irq_not_yet", 32'(irq), 32'h0);
    tick(1);
    cmp("irq_set", 32'(irq), 32'h1);
    wreg(2'd2, 32'h0000_0004);
    cmp("w1c_status", rdata & 32'hFFFF, 32'h0000);
    cmp("irq_held", 32'(irq), 32'h1);
    tick(1);
    cmp("irq_drop", 32'(irq), 32'h0);
    // set beats clear when a new rise coincides with the W1C
    pin[2] = 1'b0; tick(2);
    pin[2] = 1'b1; tick(2);
    cmp("st_before", rdata & 32'h4, 32'h4);
    pin[2] = 1'b0; tick(2);
    pin[2] = 1'b1; tick(1);
    wreg(2'd2, 32'h0000_0004);
    cmp("set_wins", rdata & 32'h4, 32'h4);
    wreg(2'd2, 32'h0000_0004);
    cmp("cleared", rdata & 32'h4, 32'h0);
    wreg(2'd3, 32'h0);
    // asynchronous reset while counting with length 8
    wreg(2'd0, 32'h0000_FF08);
    pin = 8'h20; tick(5);
    addr = 2'd2;
    rst = 1'b1; #1;
    cmp("arst_filt", 32'(filt), 32'h00);
    cmp("arst_rdata", rdata, 32'h0);
    cmp("arst_irq", 32'(irq), 32'h0);
    tick(1);
    rst = 1'b0; tick(1);
    cmp("post_rst_filt", 32'(filt), 32'h20);
    cmp("post_rst_rise", 32'(rise), 32'h20);
    // length 15, lowered to 2 after nine differing samples
    wreg(2'd0, 32'h0000_010F);
    pin = 8'h21; tick(9);
    wreg(2'd0, 32'h0000_0102);
    cmp("lower_wait", 32'(filt), 32'h20);
    tick(1);
    cmp("lower_toggle", 32'(filt), 32'h21);
    cmp("lower_rise", 32'(rise), 32'h01);
    // longest length on pin 1
    wreg(2'd0, 32'h0000_020F);
    pin[1] = 1'b1; tick(14);
    cmp("len15_wait", 32'(filt[1]), 32'h0);
    tick(1);
    cmp("len15_pass", 32'(filt[1]), 32'h1);
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
